// File: rtl/branch_psum_accum_pkg.sv
// Shared constants and post-processing helpers for the branch-merge accumulator
// and the pooling/requant blocks that reuse the same ReLU/saturation rules.
package branch_psum_accum_pkg;

    localparam int unsigned LANES_DEF = 9;
    localparam int unsigned DW_DEF    = 32;
    localparam int unsigned NBR_DEF   = 2;
    localparam int unsigned ACC_W_DEF = 40;
    localparam int unsigned DWO_DEF   = 32;
    localparam int unsigned CNT_W_DEF = 8;

    // Post-processing runs at a fixed wide width; callers sign-extend in and truncate out.
    localparam int unsigned POST_W = 64;
    typedef logic signed [POST_W-1:0] post_t;

    function automatic post_t sat_clamp(input post_t x, input int unsigned acc_w,
                                        input int unsigned dwo);
        post_t hi;
        post_t lo;
        post_t y;
        hi = (post_t'(1) <<< (dwo - 1)) - post_t'(1);
        lo = -(post_t'(1) <<< (dwo - 1));
        y  = x;
        if (dwo < acc_w) begin
            if (x > hi)
                y = hi;
            else if (x < lo)
                y = lo;
        end
        return y;
    endfunction

    function automatic post_t post_fn(input post_t x, input logic relu, input logic sat,
                                      input int unsigned acc_w, input int unsigned dwo);
        post_t y;
        y = x;
        if (relu && (x < 0))
            y = '0;
        if (sat)
            y = sat_clamp(y, acc_w, dwo);
        return y;
    endfunction

endpackage

// File: rtl/branch_psum_accum_lane.sv
// One output lane: sums the branch partial sums of a beat, accumulates across
// the group and registers the post-processed result on the final beat.
module psum_lane
    import branch_psum_accum_pkg::*;
#(
    parameter int unsigned NBR   = NBR_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned DWO   = DWO_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NBR*DW-1:0] br_data,
    input  logic              beat,
    input  logic              first,
    input  logic              last,
    input  logic              relu,
    input  logic              sat,
    output logic [DWO-1:0]    out_lane
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] lane_sum;
    logic signed [ACC_W-1:0] acc_next;

    always_comb begin
        lane_sum = '0;
        for (int unsigned b = 0; b < NBR; b++) begin
            lane_sum = lane_sum + ACC_W'($signed(br_data[b*DW +: DW]));
        end
    end

    assign acc_next = first ? lane_sum : acc + lane_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            out_lane <= '0;
        end else if (beat) begin
            acc <= acc_next;
            if (last)
                out_lane <= DWO'(post_fn(POST_W'(acc_next), relu, sat, ACC_W, DWO));
        end
    end

endmodule

// File: rtl/branch_psum_accum.sv
// RepVGG branch-merge adder: per-beat branch sum, multi-beat accumulation,
// optional ReLU/saturation, valid/ready result port.
module branch_psum_accum
    import branch_psum_accum_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned NBR   = NBR_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned DWO   = DWO_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CNT_W-1:0]        cfg_beats,
    input  logic                    cfg_relu,
    input  logic                    cfg_sat,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NBR*LANES*DW-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DWO-1:0]    out_data,
    output logic                    busy
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] beats_q;
    logic [CNT_W-1:0] beats_eff;
    logic [CNT_W-1:0] last_idx;
    logic             relu_q;
    logic             sat_q;
    logic             relu_eff;
    logic             sat_eff;
    logic             first;
    logic             last;
    logic             accept;

    // On the first beat the live cfg inputs govern, since they are latched on that same edge.
    assign first     = (cnt == '0);
    assign beats_eff = first ? cfg_beats : beats_q;
    assign relu_eff  = first ? cfg_relu  : relu_q;
    assign sat_eff   = first ? cfg_sat   : sat_q;
    assign last_idx  = (beats_eff <= CNT_W'(1)) ? '0 : beats_eff - CNT_W'(1);
    assign last      = (cnt == last_idx);

    assign in_ready = !(last && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (cnt != '0) || out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            beats_q   <= '0;
            relu_q    <= 1'b0;
            sat_q     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept && first) begin
                beats_q <= cfg_beats;
                relu_q  <= cfg_relu;
                sat_q   <= cfg_sat;
            end
            if (accept)
                cnt <= last ? '0 : cnt + CNT_W'(1);
            if (accept && last)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [NBR*DW-1:0] br;
        for (genvar b = 0; b < NBR; b++) begin : g_br
            assign br[b*DW +: DW] = in_data[(b*LANES+i)*DW +: DW];
        end

        psum_lane #(
            .NBR   (NBR),
            .DW    (DW),
            .ACC_W (ACC_W),
            .DWO   (DWO)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .br_data  (br),
            .beat     (accept),
            .first    (first),
            .last     (last),
            .relu     (relu_eff),
            .sat      (sat_eff),
            .out_lane (out_data[i*DWO +: DWO])
        );
    end

endmodule

// File: tb/tb_branch_psum_accum.sv
// Self-checking bench for branch_psum_accum against a plain-arithmetic group model.
module tb_branch_psum_accum;

    localparam int LANES = 9;
    localparam int DW    = 32;
    localparam int NBR   = 2;
    localparam int ACC_W = 40;
    localparam int DWO   = 32;
    localparam int CNT_W = 8;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [CNT_W-1:0]        cfg_beats;
    logic                    cfg_relu;
    logic                    cfg_sat;
    logic                    in_valid;
    logic                    in_ready;
    logic [NBR*LANES*DW-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DWO-1:0]    out_data;
    logic                    busy;

    int total = 0;
    int bad   = 0;

    int     beat_v [NBR][LANES];
    longint macc   [LANES];

    always #5 clk = ~clk;

    branch_psum_accum #(
        .LANES (LANES),
        .DW    (DW),
        .NBR   (NBR),
        .ACC_W (ACC_W),
        .DWO   (DWO),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_beats (cfg_beats),
        .cfg_relu  (cfg_relu),
        .cfg_sat   (cfg_sat),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // ---------------- reference model ----------------
    function automatic logic [DWO-1:0] model_post(input longint acc, input bit relu, input bit sat);
        longint x;
        longint lim;
        x   = (acc <<< (64 - ACC_W)) >>> (64 - ACC_W);
        lim = longint'(1) << (DWO - 1);
        if (relu && x < 0) x = 0;
        if (sat) begin
            if (x > lim - 1) x = lim - 1;
            else if (x < -lim) x = -lim;
        end
        return x[DWO-1:0];
    endfunction

    task automatic model_beat(input bit first);
        longint s;
        for (int i = 0; i < LANES; i++) begin
            s = 0;
            for (int b = 0; b < NBR; b++) s += longint'(beat_v[b][i]);
            macc[i] = first ? s : macc[i] + s;
        end
    endtask

    function automatic logic [LANES*DWO-1:0] exp_vec(input bit relu, input bit sat);
        logic [LANES*DWO-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DWO +: DWO] = model_post(macc[i], relu, sat);
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic pack_beat();
        for (int b = 0; b < NBR; b++)
            for (int i = 0; i < LANES; i++)
                in_data[(b*LANES+i)*DW +: DW] = beat_v[b][i];
    endtask

    task automatic fill_const(input int v0, input int v1);
        for (int b = 0; b < NBR; b++)
            for (int i = 0; i < LANES; i++)
                beat_v[b][i] = (b == 0) ? v0 : ((b == 1) ? v1 : 0);
    endtask

    task automatic fill_rand();
        for (int b = 0; b < NBR; b++)
            for (int i = 0; i < LANES; i++)
                beat_v[b][i] = ($urandom % 2 == 0) ? int'($urandom)
                                                   : int'($urandom_range(0, 200)) - 100;
    endtask

    // Inputs are driven at the falling edge; in_ready is sampled 1 unit later, outputs 1 unit after the rising edge.
    task automatic tick(output bit acc, output bit rdy);
        #1;
        rdy = in_ready;
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cfg_beats = '0; cfg_relu = 1'b0; cfg_sat = 1'b0; in_data = '0;
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_saturate();
        bit acc, rdy;
        logic [LANES*DWO-1:0] exp;
        @(negedge clk);
        cfg_beats = 8'd1; cfg_relu = 1'b0; cfg_sat = 1'b1; out_ready = 1'b1;
        fill_rand();
        beat_v[0][0] = 5;            beat_v[1][0] = -3;
        beat_v[0][8] = 32'h7FFFFFFF; beat_v[1][8] = 32'h7FFFFFFF;
        pack_beat(); in_valid = 1'b1;
        model_beat(1'b1); exp = exp_vec(1'b0, 1'b1);
        tick(acc, rdy);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL sat_accept got=%b exp=1", acc); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sat_out_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== exp) begin bad++; $display("FAIL sat_data got=%h exp=%h", out_data, exp); end
        total++; if (out_data[0 +: DWO] !== 32'd2) begin bad++; $display("FAIL sat_lane0 got=%h exp=2", out_data[0 +: DWO]); end
        total++; if (out_data[8*DWO +: DWO] !== 32'h7FFFFFFF) begin bad++; $display("FAIL sat_lane8 got=%h exp=7fffffff", out_data[8*DWO +: DWO]); end
        @(negedge clk); in_valid = 1'b0;
        tick(acc, rdy);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sat_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_accumulate();
        bit acc, rdy;
        logic [LANES*DWO-1:0] exp;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cfg_beats = 8'd4; cfg_relu = 1'b0; cfg_sat = 1'b1; out_ready = 1'b1;
            fill_const(10, 1); pack_beat(); in_valid = 1'b1;
            model_beat(k == 0);
            tick(acc, rdy);
            if (k < 3) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL acc_early_valid beat=%0d got=%b exp=0", k, out_valid); end
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL acc_busy beat=%0d got=%b exp=1", k, busy); end
            end
        end
        exp = exp_vec(1'b0, 1'b1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL acc_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== exp) begin bad++; $display("FAIL acc_data got=%h exp=%h", out_data, exp); end
        total++; if (out_data[4*DWO +: DWO] !== 32'd44) begin bad++; $display("FAIL acc_lane4 got=%0d exp=44", out_data[4*DWO +: DWO]); end
        @(negedge clk); in_valid = 1'b0;
        tick(acc, rdy);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL acc_one_cycle got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL acc_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_relu_trunc();
        bit acc, rdy;
        bit relu, sat;
        logic [DWO-1:0] want;
        logic [LANES*DWO-1:0] exp;
        for (int pass = 0; pass < 2; pass++) begin
            relu = (pass == 0); sat = (pass == 0);
            want = (pass == 0) ? 32'd0 : 32'hFFFFFFF7;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                cfg_beats = 8'd3; out_ready = 1'b1;
                // cfg flips after the first beat must not affect the group
                cfg_relu = (k == 0) ? relu : !relu;
                cfg_sat  = (k == 0) ? sat : !sat;
                fill_const((k == 2) ? 5 : -7, 0); pack_beat(); in_valid = 1'b1;
                model_beat(k == 0);
                tick(acc, rdy);
            end
            exp = exp_vec(relu, sat);
            total++; if (out_data[2*DWO +: DWO] !== want) begin bad++; $display("FAIL relu_lane2 pass=%0d got=%h exp=%h", pass, out_data[2*DWO +: DWO], want); end
            total++; if (out_data !== exp) begin bad++; $display("FAIL relu_data pass=%0d got=%h exp=%h", pass, out_data, exp); end
        end
        @(negedge clk); in_valid = 1'b0;
        tick(acc, rdy);
    endtask

    task automatic test_backpressure();
        bit acc, rdy;
        logic [LANES*DWO-1:0] exp_a, exp_b;
        @(negedge clk);
        cfg_beats = 8'd1; cfg_relu = 1'b0; cfg_sat = 1'b1; out_ready = 1'b0;
        fill_rand(); pack_beat(); in_valid = 1'b1;
        model_beat(1'b1); exp_a = exp_vec(1'b0, 1'b1);
        tick(acc, rdy);
        total++; if (out_data !== exp_a) begin bad++; $display("FAIL bp_first got=%h exp=%h", out_data, exp_a); end
        @(negedge clk);
        fill_rand(); pack_beat();
        for (int k = 0; k < 2; k++) begin
            tick(acc, rdy);
            total++; if (rdy !== 1'b0) begin bad++; $display("FAIL bp_stall cyc=%0d got=%b exp=0", k, rdy); end
            total++; if (out_valid !== 1'b1 || out_data !== exp_a) begin bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/%h", k, out_valid, out_data, exp_a); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        tick(acc, rdy);
        model_beat(1'b1); exp_b = exp_vec(1'b0, 1'b1);
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", rdy); end
        total++; if (out_valid !== 1'b1 || out_data !== exp_b) begin bad++; $display("FAIL bp_second got=%b/%h exp=1/%h", out_valid, out_data, exp_b); end
        @(negedge clk); in_valid = 1'b0;
        tick(acc, rdy);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_cfg_change();
        bit acc, rdy;
        logic [LANES*DWO-1:0] exp;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cfg_beats = (k == 0) ? 8'd4 : 8'd2; cfg_relu = 1'b0; cfg_sat = 1'b0; out_ready = 1'b1;
            fill_rand(); pack_beat(); in_valid = 1'b1;
            model_beat(k == 0);
            tick(acc, rdy);
            if (k < 3) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL cfg_early beat=%0d got=%b exp=0", k, out_valid); end
            end
        end
        exp = exp_vec(1'b0, 1'b0);
        total++; if (out_valid !== 1'b1 || out_data !== exp) begin bad++; $display("FAIL cfg_close got=%b/%h exp=1/%h", out_valid, out_data, exp); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cfg_beats = 8'd0; cfg_sat = 1'b1;
            fill_rand(); pack_beat(); in_valid = 1'b1;
            model_beat(1'b1); exp = exp_vec(1'b0, 1'b1);
            tick(acc, rdy);
            total++; if (out_valid !== 1'b1 || out_data !== exp) begin bad++; $display("FAIL cfg_zero beat=%0d got=%b/%h exp=1/%h", k, out_valid, out_data, exp); end
        end
        @(negedge clk); in_valid = 1'b0;
        tick(acc, rdy);
    endtask

    task automatic test_reset_mid();
        bit acc, rdy;
        logic [LANES*DWO-1:0] exp;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            cfg_beats = 8'd4; cfg_relu = 1'b0; cfg_sat = 1'b1; out_ready = 1'b1;
            fill_rand(); pack_beat(); in_valid = 1'b1;
            tick(acc, rdy);
        end
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cfg_beats = 8'd1;
        fill_const(3, 0); pack_beat(); in_valid = 1'b1;
        model_beat(1'b1); exp = exp_vec(1'b0, 1'b1);
        tick(acc, rdy);
        total++; if (out_valid !== 1'b1 || out_data !== exp) begin bad++; $display("FAIL rstmid_data got=%b/%h exp=1/%h", out_valid, out_data, exp); end
        total++; if (out_data[0 +: DWO] !== 32'd3) begin bad++; $display("FAIL rstmid_lane0 got=%0d exp=3", out_data[0 +: DWO]); end
        @(negedge clk); in_valid = 1'b0;
        tick(acc, rdy);
    endtask

    task automatic test_random();
        bit acc, rdy;
        int  m_cnt = 0;
        int  m_b = 1;
        bit  m_relu = 0, m_sat = 0, m_ov = 0;
        bit  m_first, m_last, exp_rdy;
        int  b_now;
        logic [LANES*DWO-1:0] m_od = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            cfg_beats = CNT_W'($urandom_range(0, 4));
            cfg_relu  = $urandom % 2;
            cfg_sat   = $urandom % 2;
            fill_rand(); pack_beat();
            m_first = (m_cnt == 0);
            b_now   = m_first ? ((cfg_beats == 0) ? 1 : int'(cfg_beats)) : m_b;
            m_last  = (m_cnt == b_now - 1);
            exp_rdy = !(m_last && m_ov && !out_ready);
            tick(acc, rdy);
            total++; if (rdy !== exp_rdy) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, rdy, exp_rdy); end
            if (in_valid && exp_rdy) begin
                if (m_first) begin m_b = b_now; m_relu = cfg_relu; m_sat = cfg_sat; end
                model_beat(m_first);
                if (m_last) begin
                    m_od = exp_vec(m_relu, m_sat); m_ov = 1; m_cnt = 0;
                end else begin
                    m_cnt++;
                    if (out_ready) m_ov = 0;
                end
            end else if (out_ready) begin
                m_ov = 0;
            end
            total++; if (out_valid !== m_ov) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, out_valid, m_ov); end
            total++; if (busy !== (m_cnt != 0 || m_ov)) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, (m_cnt != 0 || m_ov)); end
            if (m_ov) begin
                total++; if (out_data !== m_od) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, out_data, m_od); end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_saturate();
        test_accumulate();
        test_relu_trunc();
        test_backpressure();
        test_cfg_change();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
